// File: rtl/bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : bus_responder_pkg
// Brief  : Shared types and address decode for bus_responder.
//          Optional macro: BUS_RESPONDER_VEC_EN (reset-vector read locations).
// Rev    : 1.0
// ============================================================================
package bus_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      RGN_RAM      = 3'd0,
      RGN_IO_OUT   = 3'd1,
      RGN_IO_IN    = 3'd2,
      RGN_IO_CNT   = 3'd3,
      RGN_IO_STAT  = 3'd4,
      RGN_VEC      = 3'd5,
      RGN_UNMAPPED = 3'd6
   } region_t;

   localparam logic [15:0] c_IO_OUT_OFS  = 16'd0;
   localparam logic [15:0] c_IO_IN_OFS   = 16'd1;
   localparam logic [15:0] c_IO_CNT_OFS  = 16'd2;
   localparam logic [15:0] c_IO_STAT_OFS = 16'd3;
   localparam logic [7:0]  c_UNMAPPED_DATA = 8'hFF;

`ifdef BUS_RESPONDER_VEC_EN
   localparam logic [15:0] c_VEC_LO_ADDR = 16'hFFFC;
   localparam logic [15:0] c_VEC_HI_ADDR = 16'hFFFD;
`endif

   function automatic region_t decode_region(input logic [15:0] addr,
                                             input logic [15:0] io_base,
                                             input int          ram_aw);
      region_t rgn;
      rgn = RGN_UNMAPPED;
      if ((addr >> ram_aw) == 16'd0)              rgn = RGN_RAM;
      else if (addr == io_base + c_IO_OUT_OFS)    rgn = RGN_IO_OUT;
      else if (addr == io_base + c_IO_IN_OFS)     rgn = RGN_IO_IN;
      else if (addr == io_base + c_IO_CNT_OFS)    rgn = RGN_IO_CNT;
      else if (addr == io_base + c_IO_STAT_OFS)   rgn = RGN_IO_STAT;
`ifdef BUS_RESPONDER_VEC_EN
      else if (addr == c_VEC_LO_ADDR || addr == c_VEC_HI_ADDR) rgn = RGN_VEC;
`endif
      return rgn;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module : bus_responder_if
// Brief  : Core-side address/data bus between CPU core (master) and responder.
// Rev    : 1.0
// ============================================================================
interface bus_responder_if;
   logic        sel;
   logic [15:0] AD;
   logic        RW;
   logic [7:0]  D_out;
   logic [7:0]  D_in;
   logic        rdy;

   modport master (output sel, output AD, output RW, output D_out,
                   input  D_in, input rdy);
   modport slave  (input  sel, input  AD, input  RW, input  D_out,
                   output D_in, output rdy);
endinterface
`default_nettype wire

// File: rtl/bus_responder_ram.sv
`default_nettype none
// ============================================================================
// Module : bus_responder_ram
// Brief  : Single-port synchronous RAM, one-cycle read latency, no reset.
// Rev    : 1.0
// ============================================================================
module bus_responder_ram #(
   parameter int AW = 12,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) r_mem[addr] <= wdata;
      rdata <= r_mem[addr];
   end

endmodule
`default_nettype wire

// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
// Module : bus_responder
// Brief  : RAM / IO responder for the core bus with configurable wait states.
//          Optional macro: BUS_RESPONDER_VEC_EN (reset-vector reads at FFFC/D).
// Rev    : 1.0
// ============================================================================
module bus_responder
   import bus_responder_pkg::*;
#(
   parameter int          RAM_AW    = 12,
   parameter int          WAIT_CYC  = 1,
   parameter logic [15:0] IO_BASE   = 16'hF000,
   parameter logic [15:0] RESET_VEC = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bus_responder_if.slave        bus,
   output logic [7:0]            port_out,
   input  logic [7:0]            port_in
);

   localparam logic [2:0] c_WAIT_LAST = 3'(WAIT_CYC - 1);

   state_t      r_state;
   logic [2:0]  r_wcnt;
   logic [15:0] r_addr;
   logic        r_rw;
   logic [7:0]  r_wdata;
   logic        r_rdy;
   logic [7:0]  r_d_in;
   logic [7:0]  r_port_out;
   logic [7:0]  r_cnt;
   logic [7:0]  r_pin_s1;
   logic [7:0]  r_pin_s2;
   logic        r_unmapped;
   logic [7:0]  r_io_rdata;

   region_t     w_region;
   logic        w_ram_we;
   logic [7:0]  w_ram_rdata;
   logic [7:0]  w_io_rdata;
   logic [7:0]  w_vec_data;

   assign w_region   = decode_region(r_addr, IO_BASE, RAM_AW);
   assign w_ram_we   = (r_state == ST_ACCESS) && !r_rw && (w_region == RGN_RAM);
   assign w_vec_data = r_addr[0] ? RESET_VEC[15:8] : RESET_VEC[7:0];

   // Non-RAM read data is captured in ACCESS so a status read reports the
   // flag as it was before this access updates it.
   always_comb begin
      w_io_rdata = c_UNMAPPED_DATA;
      case (w_region)
         RGN_IO_OUT:  w_io_rdata = r_port_out;
         RGN_IO_IN:   w_io_rdata = r_pin_s2;
         RGN_IO_CNT:  w_io_rdata = r_cnt;
         RGN_IO_STAT: w_io_rdata = {7'b0, r_unmapped};
         RGN_VEC:     w_io_rdata = w_vec_data;
         default:     w_io_rdata = c_UNMAPPED_DATA;
      endcase
   end

   bus_responder_ram #(
      .AW (RAM_AW),
      .DW (8)
   ) u_ram (
      .clk   (clk),
      .we    (w_ram_we),
      .addr  (r_addr[RAM_AW-1:0]),
      .wdata (r_wdata),
      .rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_wcnt     <= 3'd0;
         r_addr     <= 16'h0000;
         r_rw       <= 1'b1;
         r_wdata    <= 8'h00;
         r_rdy      <= 1'b0;
         r_d_in     <= 8'h00;
         r_port_out <= 8'h00;
         r_cnt      <= 8'h00;
         r_pin_s1   <= 8'h00;
         r_pin_s2   <= 8'h00;
         r_unmapped <= 1'b0;
         r_io_rdata <= 8'h00;
      end else begin
         r_cnt    <= r_cnt + 8'd1;
         r_pin_s1 <= port_in;
         r_pin_s2 <= r_pin_s1;
         r_rdy    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.sel) begin
                  r_addr  <= bus.AD;
                  r_rw    <= bus.RW;
                  r_wdata <= bus.D_out;
                  r_wcnt  <= 3'd0;
                  r_state <= (WAIT_CYC > 0) ? ST_WAIT : ST_ACCESS;
               end
            end
            ST_WAIT: begin
               r_wcnt <= r_wcnt + 3'd1;
               if (r_wcnt == c_WAIT_LAST) r_state <= ST_ACCESS;
            end
            ST_ACCESS: begin
               r_unmapped <= (w_region == RGN_UNMAPPED);
               if (!r_rw && w_region == RGN_IO_OUT) r_port_out <= r_wdata;
               r_io_rdata <= w_io_rdata;
               r_state    <= ST_DONE;
            end
            ST_DONE: begin
               r_rdy <= 1'b1;
               if (r_rw) r_d_in <= (w_region == RGN_RAM) ? w_ram_rdata : r_io_rdata;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.D_in = r_d_in;
   assign bus.rdy  = r_rdy;
   assign port_out = r_port_out;

endmodule
`default_nettype wire

// File: tb/tb_bus_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_responder
// Brief  : Directed scoreboard bench for bus_responder.
// Rev    : 1.0
// ============================================================================
module tb_bus_responder;

   localparam int          WAIT_CYC  = 1;
   localparam logic [15:0] RESET_VEC = 16'hE000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] port_in;
   logic [7:0] port_out;

   bus_responder_if bif ();

   bus_responder #(
      .RAM_AW    (12),
      .WAIT_CYC  (WAIT_CYC),
      .IO_BASE   (16'hF000),
      .RESET_VEC (RESET_VEC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bif.slave),
      .port_out (port_out),
      .port_in  (port_in)
   );

   always #5 clk = ~clk;

   logic [7:0] sb_data [$];
   int         sb_issue[$];
   string      sb_name [$];

   int         n_chk  = 0;
   int         n_pass = 0;
   int         n_rdy  = 0;
   int         tb_cyc = 0;
   logic [7:0] e_cnt  = 8'h00;
   logic [7:0] last_rd = 8'h00;
   logic [7:0] mon_data;
   int         mon_issue;
   string      mon_name;

   // Edges seen with reset released, mirroring the free-running counter.
   always @(posedge clk) begin
      tb_cyc = tb_cyc + 1;
      if (!rst_n) e_cnt = 8'h00;
      else        e_cnt = e_cnt + 8'd1;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %02h expected %02h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && bif.rdy === 1'b1) begin
         n_rdy = n_rdy + 1;
         if (sb_data.size() == 0) begin
            n_chk = n_chk + 1;
            $display("FAIL spurious_rdy: got rdy=1 expected no pending request (cycle %0d)", tb_cyc);
         end else begin
            mon_data  = sb_data.pop_front();
            mon_issue = sb_issue.pop_front();
            mon_name  = sb_name.pop_front();
            check({mon_name, " data"}, bif.D_in, mon_data);
            check({mon_name, " latency"}, 8'(tb_cyc - mon_issue), 8'(WAIT_CYC + 2));
         end
      end
   end

   task automatic wait_rdy(input int start, input string name);
      for (int i = 0; i < 20 && n_rdy == start; i++) @(negedge clk);
      if (n_rdy == start) begin
         n_chk = n_chk + 1;
         $display("FAIL %s timeout: got no rdy expected rdy within 20 cycles", name);
         sb_data.delete(); sb_issue.delete(); sb_name.delete();
      end
   endtask

   task automatic req(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                      input logic [7:0] rexp, input bit is_cnt, input string name);
      int start;
      @(negedge clk);
      bif.sel = 1'b1; bif.AD = addr; bif.RW = rw; bif.D_out = wd;
      if (rw) last_rd = is_cnt ? 8'(e_cnt + 8'(WAIT_CYC + 1)) : rexp;
      sb_data.push_back(last_rd); sb_issue.push_back(tb_cyc + 1); sb_name.push_back(name);
      start = n_rdy;
      @(negedge clk);
      // Scramble the bus after the sample to show the request was latched.
      bif.sel = 1'b0; bif.AD = 16'hDEAD; bif.RW = ~rw; bif.D_out = 8'h99;
      wait_rdy(start, name);
   endtask

   initial begin
      int start;
      bif.sel = 1'b0; bif.AD = 16'h0000; bif.RW = 1'b1; bif.D_out = 8'h00;
      port_in = 8'h81;
      repeat (3) @(negedge clk);
      check("reset rdy", {7'b0, bif.rdy}, 8'h00);
      check("reset D_in", bif.D_in, 8'h00);
      check("reset port_out", port_out, 8'h00);
      rst_n = 1'b1;

      req(1'b0, 16'h0010, 8'h11, 8'h00, 1'b0, "wr_0010");
      req(1'b1, 16'h0010, 8'h00, 8'h11, 1'b0, "rd_0010");
      req(1'b0, 16'hF000, 8'h3C, 8'h00, 1'b0, "wr_port_3c");
      check("port_out 3c", port_out, 8'h3C);

      // Write aborted by reset while still waiting
      @(negedge clk);
      bif.sel = 1'b1; bif.AD = 16'h0010; bif.RW = 1'b0; bif.D_out = 8'hEE;
      @(negedge clk);
      bif.sel = 1'b0;
      rst_n = 1'b0;
      #1;
      check("abort rdy", {7'b0, bif.rdy}, 8'h00);
      check("abort D_in", bif.D_in, 8'h00);
      check("abort port_out", port_out, 8'h00);
      repeat (3) @(negedge clk);
      check("abort rdy held", {7'b0, bif.rdy}, 8'h00);
      rst_n = 1'b1;
      last_rd = 8'h00;
      req(1'b1, 16'h0010, 8'h00, 8'h11, 1'b0, "rd_0010_after_abort");

      req(1'b0, 16'h0123, 8'h5A, 8'h00, 1'b0, "wr_0123");
      req(1'b1, 16'h0123, 8'h00, 8'h5A, 1'b0, "rd_0123");

      req(1'b0, 16'hF000, 8'hC3, 8'h00, 1'b0, "wr_port_c3");
      check("port_out c3", port_out, 8'hC3);
      req(1'b1, 16'hF000, 8'h00, 8'hC3, 1'b0, "rd_port_out");
      req(1'b1, 16'hF001, 8'h00, 8'h81, 1'b0, "rd_port_in");
      req(1'b0, 16'hF001, 8'h00, 8'h00, 1'b0, "wr_port_in_ignored");
      req(1'b1, 16'hF001, 8'h00, 8'h81, 1'b0, "rd_port_in_again");

      req(1'b0, 16'h0000, 8'h42, 8'h00, 1'b0, "wr_0000");
      req(1'b1, 16'h8000, 8'h00, 8'hFF, 1'b0, "rd_unmapped");
      req(1'b1, 16'hF003, 8'h00, 8'h01, 1'b0, "status_set");
      req(1'b1, 16'h0000, 8'h00, 8'h42, 1'b0, "rd_0000");
      req(1'b1, 16'hF003, 8'h00, 8'h00, 1'b0, "status_clr");
      req(1'b1, 16'hF002, 8'h00, 8'h00, 1'b1, "rd_cycle_cnt");

      // New request offered while busy must be ignored
      @(negedge clk);
      bif.sel = 1'b1; bif.AD = 16'h0123; bif.RW = 1'b1;
      last_rd = 8'h5A;
      sb_data.push_back(last_rd); sb_issue.push_back(tb_cyc + 1); sb_name.push_back("busy_first");
      start = n_rdy;
      @(negedge clk);
      bif.AD = 16'h8000;
      @(negedge clk);
      bif.sel = 1'b0;
      wait_rdy(start, "busy_first");
      repeat (6) @(negedge clk);
      req(1'b1, 16'hF003, 8'h00, 8'h00, 1'b0, "busy_status");

`ifdef BUS_RESPONDER_VEC_EN
      req(1'b0, 16'hFFFC, 8'h77, 8'h00, 1'b0, "wr_vec_ignored");
      req(1'b1, 16'hFFFC, 8'h00, RESET_VEC[7:0], 1'b0, "rd_vec_lo");
      req(1'b1, 16'hFFFD, 8'h00, RESET_VEC[15:8], 1'b0, "rd_vec_hi");
      req(1'b1, 16'hF003, 8'h00, 8'h00, 1'b0, "vec_status");
`else
      req(1'b1, 16'hFFFC, 8'h00, 8'hFF, 1'b0, "rd_vec_lo");
      req(1'b1, 16'hFFFD, 8'h00, 8'hFF, 1'b0, "rd_vec_hi");
      req(1'b1, 16'hF003, 8'h00, 8'h01, 1'b0, "vec_status");
`endif

      repeat (4) @(negedge clk);
      if (sb_data.size() != 0) begin
         n_chk = n_chk + 1;
         $display("FAIL pending_at_end: got %0d outstanding expected 0", sb_data.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
